// File: rtl/flash_seq_pkg.sv
//============================================================================
// Package : flash_seq_pkg
// Desc    : Shared types and constants for the flash ROM read sequencer.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

package flash_seq_pkg;

  localparam int ADR_W = 22;   // flat word address presented by a requester
  localparam int DAT_W = 16;   // ROM data / register width
  localparam int HI_W  = 6;    // address bits held in the high register

  // ROM register indices
  localparam logic REG_ALO = 1'b0;
  localparam logic REG_AHI = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_HI = 3'd1,
    ST_WR_LO = 3'd2,
    ST_RD    = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/flash_seq_if.sv
//============================================================================
// Interface : flash_seq_if
// Desc      : Wishbone master/slave signal bundle for the ROM register port.
// Rev       : 1.0  initial release
//============================================================================
`default_nettype none

interface flash_seq_if;
  import flash_seq_pkg::*;

  logic [DAT_W-1:0] wb_dat_o;
  logic [DAT_W-1:0] wb_dat_i;
  logic             wb_adr_o;
  logic             wb_we_o;
  logic [1:0]       wb_sel_o;
  logic             wb_stb_o;
  logic             wb_cyc_o;
  logic             wb_ack_i;

  modport master (
    output wb_dat_o, wb_adr_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_dat_o, wb_adr_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

`default_nettype wire

// File: rtl/flash_seq_arb.sv
//============================================================================
// Module : flash_seq_arb
// Desc   : Two-way round-robin arbiter with a last-grant register.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module flash_seq_arb (
  input  wire logic       wb_clk_i,
  input  wire logic       wb_rst_i,
  input  wire logic [1:0] i_req,
  input  wire logic       i_upd,
  output logic      [1:0] o_gnt
);

  // 1 means requester 1 was served last, so requester 0 wins a tie
  logic r_last;

  // One-hot grant; a tie goes to the requester not served last
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Remember who was granted when the grant is taken
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)   r_last <= 1'b1;
    else if (i_upd) r_last <= o_gnt[1];
  end

endmodule

`default_nettype wire

// File: rtl/flash_seq.sv
//============================================================================
// Module : flash_seq
// Desc   : Wishbone master sharing the indirect-addressed flash ROM between
//          two read requesters, with an address-register cache and a
//          per-phase acknowledge watchdog.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module flash_seq
  import flash_seq_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  wire logic             wb_clk_i,
  input  wire logic             wb_rst_i,
  input  wire logic             req0_i,
  input  wire logic [ADR_W-1:0] adr0_i,
  output logic                  ack0_o,
  output logic                  err0_o,
  output logic      [DAT_W-1:0] dat0_o,
  input  wire logic             req1_i,
  input  wire logic [ADR_W-1:0] adr1_i,
  output logic                  ack1_o,
  output logic                  err1_o,
  output logic      [DAT_W-1:0] dat1_o,
  input  wire logic             inv_i,
  flash_seq_if.master           wb
);

  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [ADR_W-1:0] r_cur_adr;
  logic             r_gnt;
  logic             r_cache_valid;
  logic [HI_W-1:0]  r_cache_hi;
  logic [DAT_W-1:0] r_cache_lo;
  logic [7:0]       r_tmo_cnt;
  logic             r_cyc, r_we, r_adr;
  logic [1:0]       r_sel;
  logic [DAT_W-1:0] r_wdat;

  logic [1:0]       w_gnt;
  logic [ADR_W-1:0] w_adr_g, w_adr_eff;
  logic             w_take, w_hi_upd, w_lo_upd, w_rd_cap, w_tmo;
  logic             w_cache_ok, w_bus_nxt;

  flash_seq_arb u_arb (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .i_req    ({req1_i, req0_i}),
    .i_upd    (w_take),
    .o_gnt    (w_gnt)
  );

  assign w_adr_g    = w_gnt[1] ? adr1_i : adr0_i;
  // The address the next bus phase will drive: fresh grant from IDLE, else latched
  assign w_adr_eff  = (r_state == ST_IDLE) ? w_adr_g : r_cur_adr;
  // A same-cycle invalidate is honoured by the hit/miss decision too
  assign w_cache_ok = r_cache_valid && !inv_i;
  assign w_bus_nxt  = (w_state_nxt == ST_WR_HI) || (w_state_nxt == ST_WR_LO) ||
                      (w_state_nxt == ST_RD);

  assign wb.wb_cyc_o = r_cyc;
  assign wb.wb_stb_o = r_cyc;
  assign wb.wb_we_o  = r_we;
  assign wb.wb_adr_o = r_adr;
  assign wb.wb_sel_o = r_sel;
  assign wb.wb_dat_o = r_wdat;

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_hi_upd    = 1'b0;
    w_lo_upd    = 1'b0;
    w_rd_cap    = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_gnt) begin
          w_take = 1'b1;
          if (!w_cache_ok || (w_adr_g[ADR_W-1:DAT_W] != r_cache_hi))
            w_state_nxt = ST_WR_HI;
          else if (w_adr_g[DAT_W-1:0] != r_cache_lo)
            w_state_nxt = ST_WR_LO;
          else
            w_state_nxt = ST_RD;
        end
      end
      ST_WR_HI: begin
        if (wb.wb_ack_i) begin
          w_hi_upd    = 1'b1;
          w_state_nxt = ST_WR_LO;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR_LO: begin
        if (wb.wb_ack_i) begin
          w_lo_upd    = 1'b1;
          w_state_nxt = ST_RD;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_RD: begin
        if (wb.wb_ack_i) begin
          w_rd_cap    = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are loaded for the state being entered, so they only move on transitions
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_adr  <= REG_ALO;
      r_sel  <= 2'b00;
      r_wdat <= '0;
    end else begin
      r_cyc  <= w_bus_nxt;
      r_we   <= (w_state_nxt == ST_WR_HI) || (w_state_nxt == ST_WR_LO);
      r_adr  <= (w_state_nxt == ST_WR_HI) ? REG_AHI : REG_ALO;
      r_sel  <= w_bus_nxt ? 2'b11 : 2'b00;
      if (w_state_nxt == ST_WR_HI)
        r_wdat <= {{(DAT_W-HI_W){1'b0}}, w_adr_eff[ADR_W-1:DAT_W]};
      else if (w_state_nxt == ST_WR_LO)
        r_wdat <= w_adr_eff[DAT_W-1:0];
      else
        r_wdat <= '0;
    end
  end

  // Watchdog: restarts on every state change, counts unacknowledged bus cycles
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                      r_tmo_cnt <= 8'd0;
    else if (w_state_nxt != r_state)   r_tmo_cnt <= 8'd0;
    else if (r_cyc && !wb.wb_ack_i)    r_tmo_cnt <= r_tmo_cnt + 8'd1;
  end

  // Grant latch and address-register cache; invalidate beats a same-cycle fill
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cur_adr     <= '0;
      r_gnt         <= 1'b0;
      r_cache_valid <= 1'b0;
      r_cache_hi    <= '0;
      r_cache_lo    <= '0;
    end else begin
      if (w_take) begin
        r_cur_adr <= w_adr_g;
        r_gnt     <= w_gnt[1];
      end
      if (w_hi_upd) r_cache_hi <= r_cur_adr[ADR_W-1:DAT_W];
      if (w_lo_upd) r_cache_lo <= r_cur_adr[DAT_W-1:0];
      if (inv_i || w_tmo)  r_cache_valid <= 1'b0;
      else if (w_lo_upd)   r_cache_valid <= 1'b1;
    end
  end

  // Requester returns: ack/err pulse in DONE, data held until the next ack
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack0_o <= 1'b0;
      err0_o <= 1'b0;
      dat0_o <= '0;
      ack1_o <= 1'b0;
      err1_o <= 1'b0;
      dat1_o <= '0;
    end else begin
      ack0_o <= (w_state_nxt == ST_DONE) && !r_gnt;
      ack1_o <= (w_state_nxt == ST_DONE) &&  r_gnt;
      err0_o <= w_tmo && !r_gnt;
      err1_o <= w_tmo &&  r_gnt;
      if (w_rd_cap && !r_gnt)   dat0_o <= wb.wb_dat_i;
      else if (w_tmo && !r_gnt) dat0_o <= 16'hFFFF;
      if (w_rd_cap && r_gnt)    dat1_o <= wb.wb_dat_i;
      else if (w_tmo && r_gnt)  dat1_o <= 16'hFFFF;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flash_seq.sv
//============================================================================
// Module : tb_flash_seq
// Desc   : Self-checking bench for flash_seq with a ROM slave model and a
//          reference model of the address-register cache.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_flash_seq;
  import flash_seq_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, inv = 1'b0;
  logic [21:0] adr0 = '0, adr1 = '0;
  logic        ack0, err0, ack1, err1;
  logic [15:0] dat0, dat1;

  int n_vec = 0;
  int n_err = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  flash_seq_if bus ();

  flash_seq #(.TIMEOUT(16)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req0_i   (req0),
    .adr0_i   (adr0),
    .ack0_o   (ack0),
    .err0_o   (err0),
    .dat0_o   (dat0),
    .req1_i   (req1),
    .adr1_i   (adr1),
    .ack1_o   (ack1),
    .err1_o   (err1),
    .dat1_o   (dat1),
    .inv_i    (inv),
    .wb       (bus.slave)
  );

  // ROM contents as a function of the 22-bit word address
  function automatic logic [15:0] rom_f(input logic [21:0] a);
    return a[15:0] ^ {a[21:16], a[21:16], 4'h9} ^ 16'hA5C3;
  endfunction

  // ROM slave: combinational ack, two address registers, read through them
  logic        ack_en = 1'b1;
  logic [5:0]  s_hi = '0;
  logic [15:0] s_lo = '0;
  int          s_wr = 0;
  int          s_sel_bad = 0;
  assign bus.wb_ack_i = ack_en & bus.wb_cyc_o & bus.wb_stb_o;
  assign bus.wb_dat_i = rom_f({s_hi, s_lo});
  always @(posedge wb_clk_i) begin
    if (bus.wb_ack_i && bus.wb_we_o) begin
      s_wr <= s_wr + 1;
      if (bus.wb_adr_o) s_hi <= bus.wb_dat_o[5:0];
      else              s_lo <= bus.wb_dat_o;
    end
    if (bus.wb_stb_o && bus.wb_sel_o != 2'b11) s_sel_bad <= s_sel_bad + 1;
  end

  // Reference model of the address cache
  bit          m_valid = 0;
  logic [21:0] m_adr = '0;

  function automatic int exp_lat(input logic [21:0] a);
    if (!m_valid || a[21:16] != m_adr[21:16]) return 4;
    if (a[15:0] != m_adr[15:0]) return 3;
    return 2;
  endfunction

  task automatic do_reset();
    wb_rst_i = 1'b1;
    req0 = 0; req1 = 0; inv = 0;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    m_valid = 0;
    m_adr   = '0;
  endtask

  // One request from one requester; lat counts negedges from the request cycle
  task automatic do_req(input bit who, input logic [21:0] a, output int lat,
                        output logic [15:0] d, output logic e);
    @(posedge wb_clk_i); #1;
    if (who) begin req1 = 1; adr1 = a; end
    else     begin req0 = 1; adr0 = a; end
    lat = -1; d = 'x; e = 'x;
    for (int k = 0; k < 60; k++) begin
      @(negedge wb_clk_i);
      if ((who ? ack1 : ack0) === 1'b1) begin
        lat = k; d = who ? dat1 : dat0; e = who ? err1 : err0;
        break;
      end
    end
    @(posedge wb_clk_i); #1;
    req0 = 0; req1 = 0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    n_vec++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o,
         bus.wb_dat_o, ack0, err0, dat0, ack1, err1, dat1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b ack0=%b ack1=%b dat0=%h dat1=%h wdat=%h, want all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, ack0, ack1, dat0, dat1, bus.wb_dat_o);
    end
    do_reset();
  endtask

  task automatic test_cache_path();
    int lat; logic [15:0] d; logic e; int w0;
    logic [21:0] seq [3];
    int          wexp [3];
    seq[0] = 22'h012345; seq[1] = 22'h012346; seq[2] = 22'h012346;
    wexp[0] = 2; wexp[1] = 1; wexp[2] = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      int el;
      el = exp_lat(seq[i]);
      w0 = s_wr;
      do_req(1'b0, seq[i], lat, d, e);
      n_vec++;
      if (lat !== el || d !== rom_f(seq[i]) || e !== 1'b0) begin
        n_err++;
        $display("FAIL cache_path[%0d]: lat=%0d dat=%h err=%b, want lat=%0d dat=%h err=0",
                 i, lat, d, e, el, rom_f(seq[i]));
      end
      n_vec++;
      if (s_wr - w0 != wexp[i]) begin
        n_err++;
        $display("FAIL cache_writes[%0d]: %0d register writes, want %0d", i, s_wr - w0, wexp[i]);
      end
      m_valid = 1; m_adr = seq[i];
    end
  endtask

  task automatic test_round_robin();
    int order [$];
    logic [21:0] a0, a1;
    a0 = 22'h0A1111; a1 = 22'h152222;
    do_reset();
    @(posedge wb_clk_i); #1;
    adr0 = a0; adr1 = a1; req0 = 1; req1 = 1;
    for (int k = 0; k < 200 && order.size() < 4; k++) begin
      @(negedge wb_clk_i);
      if (ack0 === 1'b1) begin
        order.push_back(0);
        n_vec++;
        if (dat0 !== rom_f(a0)) begin
          n_err++; $display("FAIL rr_dat0: got %h want %h", dat0, rom_f(a0));
        end
      end
      if (ack1 === 1'b1) begin
        order.push_back(1);
        n_vec++;
        if (dat1 !== rom_f(a1)) begin
          n_err++; $display("FAIL rr_dat1: got %h want %h", dat1, rom_f(a1));
        end
      end
    end
    @(posedge wb_clk_i); #1;
    req0 = 0; req1 = 0;
    n_vec++;
    if (order.size() != 4) begin
      n_err++; $display("FAIL rr_count: %0d grants seen, want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (order[i] != (i % 2)) begin
          n_err++; $display("FAIL rr_order[%0d]: requester %0d, want %0d", i, order[i], i % 2);
        end
      end
    end
    m_valid = 1; m_adr = a1;
  endtask

  task automatic test_timeout();
    int lat, cyc_n; logic [15:0] d; logic e; logic [21:0] a;
    a = m_adr;
    ack_en = 0;
    @(posedge wb_clk_i); #1;
    req0 = 1; adr0 = a;
    lat = -1; cyc_n = 0; d = 'x; e = 'x;
    for (int k = 0; k < 60; k++) begin
      @(negedge wb_clk_i);
      if (ack0 === 1'b1) begin lat = k; d = dat0; e = err0; break; end
      if (bus.wb_cyc_o === 1'b1) cyc_n++;
    end
    @(posedge wb_clk_i); #1;
    req0 = 0; ack_en = 1;
    n_vec++;
    if (cyc_n != 16 || lat != 17) begin
      n_err++; $display("FAIL timeout_len: cyc high %0d cycles, ack at %0d, want 16 and 17", cyc_n, lat);
    end
    n_vec++;
    if (e !== 1'b1 || d !== 16'hFFFF) begin
      n_err++; $display("FAIL timeout_err: err=%b dat=%h, want err=1 dat=ffff", e, d);
    end
    m_valid = 0;
    do_req(1'b0, a, lat, d, e);
    n_vec++;
    if (lat != 4 || d !== rom_f(a) || e !== 1'b0) begin
      n_err++; $display("FAIL timeout_retry: lat=%0d dat=%h err=%b, want 4 %h 0", lat, d, e, rom_f(a));
    end
    m_valid = 1; m_adr = a;
  endtask

  task automatic test_inv();
    int lat; logic [15:0] d; logic e; logic [21:0] a, b;
    a = 22'h2ABCDE; b = 22'h2A0001;
    do_req(1'b1, a, lat, d, e);
    m_valid = 1; m_adr = a;
    @(posedge wb_clk_i); #1 inv = 1;
    @(posedge wb_clk_i); #1 inv = 0;
    m_valid = 0;
    do_req(1'b1, a, lat, d, e);
    n_vec++;
    if (lat != 4 || d !== rom_f(a)) begin
      n_err++; $display("FAIL inv_idle: lat=%0d dat=%h, want 4 %h", lat, d, rom_f(a));
    end
    m_valid = 1; m_adr = a;
    // low-half miss with invalidate landing in the WR_LO cycle
    @(posedge wb_clk_i); #1;
    req0 = 1; adr0 = b;
    @(posedge wb_clk_i); #1 inv = 1;
    @(posedge wb_clk_i); #1 inv = 0;
    lat = -1;
    for (int k = 2; k < 40; k++) begin
      @(negedge wb_clk_i);
      if (ack0 === 1'b1) begin lat = k; d = dat0; break; end
    end
    @(posedge wb_clk_i); #1 req0 = 0;
    n_vec++;
    if (lat != 3 || d !== rom_f(b)) begin
      n_err++; $display("FAIL inv_during: lat=%0d dat=%h, want 3 %h", lat, d, rom_f(b));
    end
    m_valid = 0;
    do_req(1'b0, b, lat, d, e);
    n_vec++;
    if (lat != 4 || d !== rom_f(b)) begin
      n_err++; $display("FAIL inv_wins: lat=%0d dat=%h, want 4 %h", lat, d, rom_f(b));
    end
    m_valid = 1; m_adr = b;
  endtask

  task automatic test_reset_mid();
    int lat, acks; logic [15:0] d; logic e; logic [21:0] a;
    a = 22'h3F0F0F;
    @(posedge wb_clk_i); #1;
    req0 = 1; adr0 = a;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i); #1;
    n_vec++;
    if (bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b1 || bus.wb_adr_o !== REG_ALO) begin
      n_err++; $display("FAIL rstmid_in_wrlo: cyc=%b we=%b adr=%b, want 1 1 0",
                        bus.wb_cyc_o, bus.wb_we_o, bus.wb_adr_o);
    end
    wb_rst_i = 1; #1;
    n_vec++;
    if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_drop: cyc=%b stb=%b, want 0 0", bus.wb_cyc_o, bus.wb_stb_o);
    end
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge wb_clk_i);
      if (ack0 !== 1'b0 || ack1 !== 1'b0) acks++;
    end
    req0 = 0;
    @(posedge wb_clk_i); #1 wb_rst_i = 0;
    m_valid = 0; m_adr = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge wb_clk_i);
      if (ack0 !== 1'b0 || ack1 !== 1'b0) acks++;
    end
    n_vec++;
    if (acks != 0) begin
      n_err++; $display("FAIL rstmid_noack: %0d cycles with ack, want 0", acks);
    end
    do_req(1'b0, a, lat, d, e);
    n_vec++;
    if (lat != 4 || d !== rom_f(a)) begin
      n_err++; $display("FAIL rstmid_after: lat=%0d dat=%h, want 4 %h", lat, d, rom_f(a));
    end
    m_valid = 1; m_adr = a;
  endtask

  task automatic test_random();
    int lat, el; logic [15:0] d; logic e; logic [21:0] a; bit who;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(4) == 0) begin
        @(posedge wb_clk_i); #1 inv = 1;
        @(posedge wb_clk_i); #1 inv = 0;
        m_valid = 0;
      end
      case ($urandom_range(2))
        0:       a = m_adr;
        1:       a = {m_adr[21:16], 16'($urandom)};
        default: a = 22'($urandom);
      endcase
      who = 1'($urandom);
      el  = exp_lat(a);
      do_req(who, a, lat, d, e);
      n_vec++;
      if (lat != el || d !== rom_f(a) || e !== 1'b0) begin
        n_err++; $display("FAIL random[%0d]: req%0d adr=%h lat=%0d dat=%h err=%b, want lat=%0d dat=%h err=0",
                          i, who, a, lat, d, e, el, rom_f(a));
      end
      m_valid = 1; m_adr = a;
    end
    n_vec++;
    if (s_sel_bad != 0) begin
      n_err++; $display("FAIL sel: %0d strobe cycles with sel!=11, want 0", s_sel_bad);
    end
  endtask

  initial begin
    test_reset();
    test_cache_path();
    test_round_robin();
    test_timeout();
    test_inv();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/flash_seq.md
Name: flash_seq

Overview:
- Wishbone master that shares the indirect-addressed BIOS/flash ROM between two read requesters.
- Each requester presents a flat 22-bit word address. The block programs the ROM's address registers (index 0 holds the low 16 bits, index 1 holds the high 6 bits), reads the data word and returns it.
- It keeps a copy of the last-programmed address so it can skip redundant register writes.
- A timeout watchdog aborts accesses that are never acknowledged.

Parameters:
- TIMEOUT, 16: cycles a bus phase may wait for wb_ack_i before the access is aborted. Legal range 2..255.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous reset, active-high
- req0_i  in  1  requester 0 read request (level)
- adr0_i  in  22  requester 0 word address
- ack0_o  out  1  requester 0 done pulse
- err0_o  out  1  requester 0 timeout pulse (coincident with ack0_o)
- dat0_o  out  16  requester 0 read data
- req1_i, adr1_i, ack1_o, err1_o, dat1_o: same as requester 0, for requester 1
- inv_i  in  1  invalidate address cache (an external agent rewrote the ROM registers)
- wb_dat_o  out  16  master write data
- wb_dat_i  in  16  master read data
- wb_adr_o  out  1  ROM register index
- wb_we_o  out  1  write enable
- wb_sel_o  out  2  byte selects, always 2'b11 while stb is high
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  slave acknowledge (the ROM acknowledges combinationally)

Behaviour:
- Reset (asynchronous): state IDLE; every output 0; cache_valid 0; cached address 0; priority pointer favours requester 0; timeout counter 0.
- States: IDLE, WR_HI, WR_LO, RD, DONE.
- IDLE:
  - Samples req0_i and req1_i.
  - If exactly one is high, grant it. If both are high, grant the one not granted last.
  - Latch the granted address into cur_adr.
  - Next state:
    - WR_HI if !cache_valid or cur_adr[21:16] differs from the cached high bits;
    - else WR_LO if cur_adr[15:0] differs from the cached low bits;
    - else RD.
- WR_HI: cyc=stb=we=1, adr=1, wb_dat_o={10'b0, cur_adr[21:16]}. On wb_ack_i, update the cached high bits and go to WR_LO.
- WR_LO: adr=0, wb_dat_o=cur_adr[15:0]. On wb_ack_i, update the cached low bits, set cache_valid and go to RD.
  - WR_LO is always entered after WR_HI, because the ROM's address register is not known to be coherent after a high-bits write.
- RD: cyc=stb=1, we=0, adr=0. On wb_ack_i, capture wb_dat_i into the granted requester's dat register and go to DONE.
- Bus outputs are registered and change only on state transitions. With the combinational ack, each bus phase lasts exactly one cycle.
- DONE:
  - The granted requester's ack pulses for 1 cycle; its dat output stays stable until that requester's next ack.
  - Record the granted requester as last-granted. Requests are ignored in DONE; go to IDLE.
  - The requester must hold req and adr stable until its ack, and drop req on the cycle after ack.
- Latency, counted from req first sampled high in IDLE at cycle N:
  - cache hit: ack at N+2;
  - low-half miss: ack at N+3;
  - full miss or cache invalid: ack at N+4.
- Timeout:
  - The counter clears on entry to each bus phase and increments on each cycle with no ack.
  - When it reaches TIMEOUT-1 with no ack, drop cyc and stb, clear cache_valid, set dat=16'hFFFF and go to DONE with err and ack both pulsing.
- inv_i clears cache_valid in any cycle. If it coincides with a cache update, the invalidate wins.
- inv_i during an access does not abort the access.
- Reset mid-access: cyc and stb drop immediately (asynchronous); no ack is issued.

Decomposition:
- Package flash_seq_pkg:
  - state enum;
  - REG_ALO=1'b0 and REG_AHI=1'b1;
  - ADR_W=22, DAT_W=16, HI_W=6.
- Sub-module flash_seq_arb: 2-way round-robin arbiter with a last-grant register. Inputs req[1:0] and an update strobe; output a one-hot grant.

Test Plan:
- Reset, then req0 with adr 22'h012345 (cache invalid) -> write 6'h01 to index 1, write 16'h2345 to index 0, then a read. ack0 at N+4; dat0 equals rom[22'h012345].
- Follow with req0 at 22'h012346 -> only the index 0 write and the read; ack at N+3. Repeat 22'h012346 -> read only; ack at N+2.
- req0 and req1 rise in the same cycle after reset -> requester 0 served first, then requester 1. Hold both high continuously -> grants alternate 0, 1, 0, 1.
- Slave model never acks, TIMEOUT=16 -> cyc drops after 16 cycles in WR_HI; ack0 and err0 pulse; dat0=16'hFFFF. The next request re-enters WR_HI.
- Pulse inv_i after a cached access to the same address -> the next access takes the full-miss path (ack at N+4).
- Assert wb_rst_i in the cycle the FSM is in WR_LO -> cyc and stb are 0 in that same cycle; no ack; after reset the next request takes the full-miss path.
